// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte handshake, status and serial line bundle for uart_tx_fifo
interface uart_tx_fifo_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16
);
    logic [PAYLOAD_BITS-1:0]       tx_data;
    logic                          tx_valid;
    logic                          tx_ready;
    logic                          overflow_clr;
    logic                          overflow;
    logic                          uart_txd;
    logic                          tx_busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output tx_data, tx_valid, overflow_clr,
        input  tx_ready, overflow, uart_txd, tx_busy, fifo_count
    );

    modport slave (
        input  tx_data, tx_valid, overflow_clr,
        output tx_ready, overflow, uart_txd, tx_busy, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter, 8N1-style frames, zero-gap back-to-back
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_fifo_if.slave   bus
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                   state, state_d;
    logic [CW-1:0]            cyc_cnt, cyc_d;
    logic [BW-1:0]            bit_cnt, bit_d;
    logic [PAYLOAD_BITS-1:0]  shreg;
    logic                     txd_q;
    logic                     ovf_q;
    logic                     push, pop, shift, bit_end;
    logic                     fifo_full, fifo_empty;

    logic [PAYLOAD_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              count;

`ifdef UART_TX_PARITY_EN
    logic                     par_q;
`endif

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign push       = bus.tx_valid && !fifo_full;
    assign bit_end    = (cyc_cnt == CYC_LAST);

    always_comb begin
        state_d = state;
        cyc_d   = cyc_cnt + CYC_ONE;
        bit_d   = bit_cnt;
        pop     = 1'b0;
        shift   = 1'b0;
        case (state)
            S_IDLE: begin
                cyc_d = '0;
                bit_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d = '0;
                    shift = 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_cnt + BIT_ONE;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_d = '0;
                        // Reload straight into START so consecutive frames have no idle gap.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_cnt + BIT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_d;
            cyc_cnt <= cyc_d;
            bit_cnt <= bit_d;
        end
    end

    // txd follows the registered state, so the line lags the state by one cycle uniformly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            txd_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            if (pop) begin
                shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                par_q <= ^mem[rd_ptr];
`endif
            end else if (shift) begin
                shreg <= shreg >> 1;
            end
            case (state)
                S_START:  txd_q <= 1'b0;
                S_DATA:   txd_q <= shreg[0];
`ifdef UART_TX_PARITY_EN
                S_PARITY: txd_q <= par_q;
`endif
                default:  txd_q <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (bus.tx_valid && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (bus.overflow_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.tx_ready   = !fifo_full;
    assign bus.overflow   = ovf_q;
    assign bus.uart_txd   = txd_q;
    assign bus.tx_busy    = (state != S_IDLE) || !fifo_empty;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
    localparam int CLK_HZ   = 1000000;
    localparam int BIT_RATE = 100000;
    localparam int PB       = 8;
    localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.PAYLOAD_BITS(PB), .FIFO_DEPTH(DEPTH)) bus();

    uart_tx_fifo #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // frame10: {stop, data LSB-first, start} as the line shows it; par: even parity of data
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame10;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    function automatic logic exp_bit(input vec_t v, input int k);
`ifdef UART_TX_PARITY_EN
        if (k <= 8) return v.frame10[k];
        if (k == 9) return v.par;
        return 1'b1;
`else
        return v.frame10[k];
`endif
    endfunction

    // Entered at the negedge right after txd falls; samples each bit mid-period.
    task automatic check_bits(input vec_t v);
        repeat (5) @(negedge clk);
        for (int k = 0; k < FB; k++) begin
            if (k > 0) repeat (10) @(negedge clk);
            check($sformatf("bit%0d_of_%0h", k, v.data), bus.uart_txd, exp_bit(v, k));
        end
    endtask

    task automatic send_and_check(input vec_t v);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = v.data;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("count_after_write", bus.fifo_count, 5'd1);
        check("txd_high_n", bus.uart_txd, 1'b1);
        @(negedge clk);
        check("txd_high_n1", bus.uart_txd, 1'b1);
        check("count_after_pop", bus.fifo_count, 5'd0);
        check("busy_in_frame", bus.tx_busy, 1'b1);
        @(negedge clk);
        check("start_falls_n2", bus.uart_txd, 1'b0);
        check_bits(v);
        repeat (3) @(negedge clk);
        check("busy_last_cycle", bus.tx_busy, 1'b1);
        @(negedge clk);
        check("busy_drops", bus.tx_busy, 1'b0);
    endtask

    logic [7:0] sb[$];
    logic       dec_en = 1'b0;
    int         dec_count = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (dec_en && bus.uart_txd === 1'b0) begin
                logic [7:0] b;
                repeat (5) @(negedge clk);
                check("dec_start", bus.uart_txd, 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (10) @(negedge clk);
                    b[k] = bus.uart_txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (10) @(negedge clk);
                check("dec_parity", bus.uart_txd, ^b);
`endif
                repeat (10) @(negedge clk);
                check("dec_stop", bus.uart_txd, 1'b1);
                if (sb.size() == 0) begin
                    check("dec_unexpected_byte", b, 8'hxx);
                end else begin
                    check($sformatf("dec_byte%0d", dec_count), b, sb.pop_front());
                end
                dec_count++;
            end
        end
    end

    initial begin
        vecs[0] = '{8'h55, 10'h2AA, 1'b0};
        vecs[1] = '{8'hA3, 10'h346, 1'b0};
        vecs[2] = '{8'h0F, 10'h21E, 1'b0};
        vecs[3] = '{8'h07, 10'h20E, 1'b1};
        vecs[4] = '{8'h03, 10'h206, 1'b0};
        vecs[5] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[6] = '{8'h81, 10'h302, 1'b0};
        vecs[7] = '{8'h80, 10'h300, 1'b1};

        bus.tx_valid     = 1'b0;
        bus.tx_data      = '0;
        bus.overflow_clr = 1'b0;
        reset            = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txd", bus.uart_txd, 1'b1);
        check("rst_ready", bus.tx_ready, 1'b1);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_count", bus.fifo_count, 5'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) send_and_check(vecs[i]);

        // Two consecutive writes: stop of the first frame runs straight into the next start.
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hA3;
        @(negedge clk);
        bus.tx_data  = 8'h0F;
        check("b2b_count_n", bus.fifo_count, 5'd1);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("b2b_count_n1", bus.fifo_count, 5'd1);
        @(negedge clk);
        check("b2b_count_n2", bus.fifo_count, 5'd1);
        check("b2b_start1", bus.uart_txd, 1'b0);
        check_bits(vecs[1]);
        repeat (4) @(negedge clk);
        check("b2b_stop_end", bus.uart_txd, 1'b1);
        check("b2b_count_after_pop2", bus.fifo_count, 5'd0);
        check("b2b_busy_between", bus.tx_busy, 1'b1);
        @(negedge clk);
        check("b2b_start2_no_gap", bus.uart_txd, 1'b0);
        check_bits(vecs[2]);
        repeat (3) @(negedge clk);
        check("b2b_busy_last", bus.tx_busy, 1'b1);
        @(negedge clk);
        check("b2b_busy_drops", bus.tx_busy, 1'b0);

        // Fill: 17 writes accepted (one popped), the 18th refused.
        @(negedge clk);
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.tx_data = 8'(i);
            @(negedge clk);
            if (i == 1) check("fill_count_after_pop", bus.fifo_count, 5'd1);
        end
        check("fill_count16", bus.fifo_count, 5'd16);
        check("fill_ready0", bus.tx_ready, 1'b0);
        check("fill_no_ovf_yet", bus.overflow, 1'b0);
        bus.tx_data = 8'hEE;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        check("ovf_set", bus.overflow, 1'b1);
        check("ovf_count_held", bus.fifo_count, 5'd16);
        bus.overflow_clr = 1'b1;
        @(negedge clk);
        bus.overflow_clr = 1'b0;
        check("ovf_cleared", bus.overflow, 1'b0);
        bus.tx_valid     = 1'b1;
        bus.overflow_clr = 1'b1;
        @(negedge clk);
        bus.tx_valid     = 1'b0;
        bus.overflow_clr = 1'b0;
        check("ovf_set_wins", bus.overflow, 1'b1);

        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("ovf_reset", bus.overflow, 1'b0);

        // Reset 35 cycles into a 0x00 frame (data bit 2 on the line, low).
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h00;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (34) @(negedge clk);
        check("mid_frame_low", bus.uart_txd, 1'b0);
        check("mid_frame_busy", bus.tx_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("abort_txd", bus.uart_txd, 1'b1);
        check("abort_count", bus.fifo_count, 5'd0);
        check("abort_busy", bus.tx_busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        send_and_check(vecs[6]);

        // Random stream with gaps against the serial decoder.
        dec_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int guard;
            logic [7:0] d;
            d = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            bus.tx_valid = 1'b1;
            bus.tx_data  = d;
            guard = 0;
            while (!bus.tx_ready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) check("stream_ready_timeout", 32'd0, 32'd1);
            sb.push_back(d);
            @(negedge clk);
            bus.tx_valid = 1'b0;
        end
        for (int t = 0; t < 40000 && dec_count < 200; t++) @(negedge clk);
        check("stream_decoded", dec_count, 200);
        check("stream_sb_empty", sb.size(), 0);
        repeat (20) @(negedge clk);
        check("stream_idle", bus.tx_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
